// File: rtl/stream_rand_stall.sv
// Valid/ready throttle that holds each beat back for min(rand_i, cfg_max_stall_i) cycles.
// Define STREAM_RAND_STALL_STATS_EN to add the stall_cycles_o and beats_o statistics counters.
module stream_rand_stall #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned RandWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [RandWidth-1:0] rand_i,
    output logic                 rand_req_o,
    input  logic                 cfg_enable_i,
    input  logic [RandWidth-1:0] cfg_max_stall_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
`ifdef STREAM_RAND_STALL_STATS_EN
    output logic [31:0]          stall_cycles_o,
    output logic [31:0]          beats_o,
`endif
    output logic [DataWidth-1:0] data_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        PASS  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [RandWidth-1:0] cnt_q, cnt_d;
    logic [RandWidth-1:0] stall_len;

    assign stall_len = (rand_i < cfg_max_stall_i) ? rand_i : cfg_max_stall_i;
    assign data_o    = data_i;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_o    = 1'b0;
        ready_o    = 1'b0;
        rand_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cfg_enable_i) begin
                    valid_o = valid_i;
                    ready_o = ready_i;
                end else if (valid_i) begin
                    // Gated by reset so the generator is never advanced while held in reset.
                    rand_req_o = rst_ni;
                    cnt_d      = stall_len;
                    state_d    = (stall_len != '0) ? STALL : PASS;
                end
            end
            STALL: begin
                if (cnt_q <= RandWidth'(1)) begin
                    cnt_d   = '0;
                    state_d = PASS;
                end else begin
                    cnt_d = cnt_q - RandWidth'(1);
                end
            end
            PASS: begin
                valid_o = valid_i;
                ready_o = ready_i;
                if (valid_i && ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STREAM_RAND_STALL_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] beats_q;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q <= '0;
            beats_q        <= '0;
        end else begin
            if (state_q == STALL && stall_cycles_q != '1) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (valid_o && ready_i && beats_q != '1) begin
                beats_q <= beats_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign beats_o        = beats_q;
`endif

endmodule

// File: doc/stream_rand_stall.md
Name: stream_rand_stall

Overview:
- Valid/ready stream throttle that inserts pseudo-random stall cycles before each beat.
- Stall lengths come from the pseudo-random generator block: it drives that block's enable input and takes its output bits.
- Used in testbenches and for random back-pressure/jitter insertion on SoC-internal streams.

Parameters:
- DataWidth, 32, width of the payload passed through.
- RandWidth, 8, width of the random input; it is also the width of the stall counter and of the max-stall configuration.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- rand_i  in  RandWidth  random value from the generator's out_o.
- rand_req_o  out  1  one-cycle pulse that advances the generator; connects to the generator's en_i.
- cfg_enable_i  in  1  1 = throttling active; 0 = combinational bypass.
- cfg_max_stall_i  in  RandWidth  upper bound on stall cycles per beat.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_i  in  DataWidth  upstream payload.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- data_o  out  DataWidth  downstream payload; always equals data_i.

Behaviour:
- Clock, reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: state IDLE, stall counter 0, rand_req_o 0. valid_o and ready_o follow the IDLE rules below.
- Stall length: stall = min(rand_i, cfg_max_stall_i), unsigned RandWidth compare. It is sampled only in the IDLE load cycle.
- IDLE, cfg_enable_i=0 (bypass):
  - valid_o=valid_i, ready_o=ready_i.
  - No state change, rand_req_o=0.
- IDLE, cfg_enable_i=1:
  - valid_o=0, ready_o=0.
  - If valid_i=1: load counter=stall and pulse rand_req_o for exactly this cycle.
  - Next state is STALL if stall!=0, otherwise PASS.
- STALL:
  - valid_o=0, ready_o=0.
  - Counter decrements each cycle; when counter==1 the next state is PASS.
  - Exactly `stall` cycles are spent in STALL.
- PASS:
  - valid_o=valid_i, ready_o=ready_i.
  - On valid_i&&ready_i the next state is IDLE. Otherwise stay in PASS; valid_o holds while valid_i holds.
- Latency: with throttling active, valid_o rises stall+1 cycles after valid_i is first seen in IDLE. The IDLE load cycle always costs 1 cycle, so back-to-back throughput is at most 1 beat per 2 cycles.
- Upstream protocol:
  - valid_i must stay high until the handshake; data_i must stay stable.
  - If valid_i drops in STALL, counting continues. If it is low on reaching PASS, the block waits in PASS with valid_o=0.
- cfg_enable_i: only evaluated in IDLE. A change mid-beat (STALL/PASS) takes effect after the current beat completes.
- cfg_max_stall_i=0: every beat goes IDLE->PASS, i.e. exactly 1 cycle of added latency. rand_req_o still pulses.
- rand_i=all-ones with cfg_max_stall_i=all-ones: stall=2^RandWidth-1, and the counter does not wrap.
- Generator pacing: rand_req_o pulses exactly once per accepted beat while enabled, never in bypass.
- Async reset asserted during STALL/PASS: returns to IDLE immediately and the in-flight beat is dropped from the block's view. Upstream re-presents the beat; valid_o deasserts at once.

Optional Feature:
- Macro: STREAM_RAND_STALL_STATS_EN.
- Defined:
  - Adds output stall_cycles_o, 32 bits: saturating count of cycles spent in STALL since reset.
  - Reset value 0; it holds at 32'hFFFF_FFFF and does not wrap.
  - Adds output beats_o, 32 bits: saturating count of downstream handshakes, counted in both bypass and throttled modes.
- Not defined: neither port nor its counters exist; the behaviour is otherwise identical.

Test Plan:
- Reset, enable=1, valid_i=0, held 10 cycles -> valid_o=0, ready_o=0, rand_req_o=0 throughout.
- enable=1, max=15, rand_i=5, valid_i=1, ready_i=1 -> rand_req_o pulses in cycle 0. valid_o is 0 in cycles 0..5 and 1 in cycle 6; the handshake happens in cycle 6 and the state is IDLE in cycle 7.
- enable=1, max=3, rand_i=200 -> stall clipped to 3; valid_o rises 4 cycles after valid_i.
- enable=0, valid_i=1 and ready_i toggling 1,0,1 -> valid_o/ready_o mirror inputs combinationally, 2 handshakes, no rand_req_o pulses.
- enable=1, rand_i=0xFF, max=0xFF, ready_i=0 in PASS for 3 cycles -> 255 STALL cycles. valid_o stays high for the 3 cycles and the handshake happens on the 4th. With STREAM_RAND_STALL_STATS_EN: stall_cycles_o=255, beats_o=1.
- rst_ni asserted mid-STALL with counter=4 -> state IDLE immediately, valid_o=0. After release with valid_i=1, a fresh stall is sampled and rand_req_o pulses again.
